// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_e  : responder FSM state encoding
//   CntWidth    : width of the read-latency down-counter (covers latencies up to 15)
//   read_lat_ok : legality check for the READ_LAT parameter
package dm_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } dm_state_e;

    localparam int unsigned CntWidth = $clog2(16);

    function automatic bit read_lat_ok(input int unsigned lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/dm_array.sv
// Data-memory storage: DEPTH x DATA_WIDTH words.
//   clk, rst : clock (rising edge) and async active-low clear of every word
//   we       : write enable; the caller only enables in-range writes
//   waddr    : write word address
//   wdata    : write data
//   raddr    : combinational read address
//   rdata    : read data, 0 when raddr is out of range
module dm_array #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr[IdxW-1:0]] <= wdata;
        end
    end

    // No wrap-around: upper address bits must be zero-ranged, else read 0.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem[raddr[IdxW-1:0]];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage of the 16-bit pipeline.
//   clk, rst    : clock (rising edge), async active-low reset
//   dm_rd_i     : read request          dm_wr_i    : write request
//   dm_addr_i   : word address          dm_wdata_i : write data
//   dm_rdata_o  : registered read data for WB
//   dm_rvalid_o : one-cycle pulse when dm_rdata_o updates
//   dm_stall_o  : hold MEM / freeze earlier stages while a multi-cycle read runs
//   dm_err_o    : sticky error (out-of-range access or rd+wr together)
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dm_rd_i,
    input  logic                  dm_wr_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_rvalid_o,
    output logic                  dm_stall_o,
    output logic                  dm_err_o
);

    if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
        $fatal(1, "dm_responder: READ_LAT must be in 1..15");
    end

    localparam logic [CntWidth-1:0] CntInit = CntWidth'(READ_LAT - 1);

    dm_state_e             state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  stall;
    logic                  arr_we;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] arr_raddr;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign in_range  = 32'(dm_addr_i) < DEPTH;
    // While waiting, the stalled pipeline holds the address, but use the latched copy anyway.
    assign arr_raddr = (state_q == StWait) ? addr_q : dm_addr_i;

    dm_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .waddr(dm_addr_i),
        .wdata(dm_wdata_i),
        .raddr(arr_raddr),
        .rdata(arr_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        stall    = 1'b0;
        arr_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dm_wr_i) begin
                    // Write wins over a simultaneous read; that combination is an error.
                    arr_we = in_range;
                    if (!in_range || dm_rd_i) err_d = 1'b1;
                end else if (dm_rd_i) begin
                    if (!in_range) err_d = 1'b1;
                    if (READ_LAT == 1) begin
                        rdata_d  = arr_rdata;
                        rvalid_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = dm_addr_i;
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Stall drops one cycle early so data lands as the instruction enters WB.
                stall = cnt_q > CntWidth'(1);
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q == CntWidth'(1)) begin
                    rdata_d  = arr_rdata;
                    rvalid_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign dm_rdata_o  = rdata_q;
    assign dm_rvalid_o = rvalid_q;
    assign dm_stall_o  = stall;
    assign dm_err_o    = err_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the 16-bit pipelined processor. It is the target end of the MEM stage's dm_rd/dm_wr/address/write-data interface.
- Owns the data-memory array. Writes are posted in one cycle. Reads have a configurable latency, and the block raises a stall to the hazard unit while a multi-cycle read is in flight.
- Read data is presented to the WB stage for MemToReg selection.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 8, address width from MEM.
- DEPTH, 256, implemented words (1..2^ADDR_WIDTH); addresses >= DEPTH are out of range.
- READ_LAT, 1, cycles from read acceptance to data valid (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dm_rd_i  in  1  read request from MEM.
- dm_wr_i  in  1  write request from MEM.
- dm_addr_i  in  ADDR_WIDTH  word address.
- dm_wdata_i  in  DATA_WIDTH  write data.
- dm_rdata_o  out  DATA_WIDTH  registered read data for WB.
- dm_rvalid_o  out  1  one-cycle pulse: dm_rdata_o updated this cycle.
- dm_stall_o  out  1  to hazard unit: hold the MEM request and freeze the earlier stages.
- dm_err_o  out  1  sticky error: out-of-range access, or rd and wr asserted together.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE and the latency counter to 0.
  - dm_rdata_o=0, dm_rvalid_o=0, dm_err_o=0; dm_stall_o=0 once the state is IDLE.
  - Every array word is cleared to 0.
  - Reset during WAIT abandons the read: no rvalid pulse, and no write occurs.
- FSM states are IDLE and WAIT. Requests are sampled only in IDLE. In WAIT, request inputs are ignored; the stalled pipeline holds them stable.
- Write, IDLE with dm_wr_i=1 and address in range:
  - mem[addr] <= wdata at the edge.
  - No stall and no rvalid; the state stays IDLE.
- Read with READ_LAT=1, IDLE with dm_rd_i=1:
  - At the edge, dm_rdata_o <= mem[addr] and dm_rvalid_o <= 1 for one cycle.
  - dm_stall_o stays 0.
- Read with READ_LAT=L>1, IDLE with dm_rd_i=1:
  - dm_stall_o=1 combinationally in the accept cycle.
  - At the edge, the address is latched, cnt <= L-1 and the state goes to WAIT.
  - In WAIT, dm_stall_o = (cnt > 1). Each edge decrements cnt.
  - At the edge where cnt==1: dm_rdata_o <= mem[latched addr], dm_rvalid_o <= 1, state returns to IDLE.
  - Total stall is L-1 cycles. Data is valid in the cycle the instruction occupies WB, the same alignment as L=1.
- Read-after-write on consecutive cycles returns the new data, because the write lands before the read samples the array.
- A write in the cycle an L>1 read is accepted cannot occur (exclusive by the rd/wr rule).
- dm_rd_i and dm_wr_i both 1:
  - The write is performed and the read is ignored.
  - dm_err_o <= 1 (sticky until reset).
- Out-of-range address (>= DEPTH):
  - A write is dropped.
  - A read returns 0 with the normal timing and rvalid.
  - dm_err_o <= 1.
- The address is used as-is; no wrap-around.
- dm_rvalid_o is never high for two consecutive cycles when READ_LAT>1.
- Idle cycles with no request: outputs hold, except dm_rvalid_o, which returns to 0.

Decomposition:
- Shared package dm_pkg holds:
  - the state encoding (IDLE=1'b0, WAIT=1'b1);
  - the counter width localparam, $clog2(16);
  - the READ_LAT legality check.
- One natural sub-module, dm_array: DEPTH x DATA_WIDTH storage with synchronous write, combinational read and async clear.
- The FSM, latency counter and error logic stay in dm_responder.

Test Plan:
- Reset mid-WAIT (READ_LAT=3): assert rst=0 one cycle after read acceptance -> no rvalid, dm_stall_o=0, dm_rdata_o=0, mem[0x10]=0 after release.
- Write then read (READ_LAT=1): wr addr 0x05 data 0xBEEF, next cycle rd 0x05 -> dm_rdata_o=0xBEEF with rvalid one cycle later, stall never asserted.
- Multi-cycle read (READ_LAT=4): preload 0x20=0x1234, rd 0x20 -> dm_stall_o high exactly 3 cycles, rvalid pulse in the cycle after stall drops, data 0x1234.
- Back-to-back reads (READ_LAT=2): rd 0x01 then rd 0x02 (values 0x0A, 0x0B) -> two rvalid pulses 2 cycles apart, correct data, 1 stall cycle each.
- Conflict: dm_rd_i=dm_wr_i=1, addr 0x07, wdata 0x5555 -> mem[0x07]=0x5555, no rvalid, dm_err_o=1 and stays 1.
- Out of range (DEPTH=128): wr 0x90 data 0xFFFF then rd 0x90 -> dm_rdata_o=0, rvalid pulses, dm_err_o=1, mem contents unchanged.
